// File: rtl/ahbl_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahbl_mem_slave
// Description : AHB-Lite responder backed by a little-endian word memory, with
//               configurable OKAY wait states and a two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_mem_slave #(
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic        cpu_clk,
    input  logic        pg_reset_b,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         DEPTH     = 1 << (ADDR_W - 2);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                write_q, write_d;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                illegal;
    logic                data_done;
    logic                commit;
    logic [3:0]          lane_en;
    logic                unused_inputs;

    assign unused_inputs = ^{hburst, hprot};

    assign accept    = hsel & htrans[1] & hready_in;
    assign illegal   = (hsize > 3'd2)
                     | ((hsize == 3'd1) & haddr[0])
                     | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
                     | ((haddr >> ADDR_W) != 32'd0);
    assign data_done = (state_q == ST_DATA) & (wcnt_q == 3'd0);
    assign commit    = data_done & write_q;

    // Outputs depend only on registered state and the array, never on the
    // address-phase inputs, so a stalled bus cannot form a combinational loop.
    assign hready_out = (state_q == ST_DATA) ? (wcnt_q == 3'd0) : (state_q != ST_ERR1);
    assign hresp      = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign hrdata     = (data_done & ~write_q) ? mem_q[addr_q[ADDR_W-1:2]] : 32'd0;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        if (hready_out) begin
            wcnt_d = 3'd0;
            if (accept) begin
                addr_d  = haddr[ADDR_W-1:0];
                size_d  = hsize[1:0];
                write_d = hwrite;
                if (illegal) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_DATA;
                    wcnt_d  = WAIT_INIT;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_DATA) begin
            wcnt_d = wcnt_q - 3'd1;
        end else begin
            state_d = ST_ERR2;
        end
    end

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            2'd0:    lane_en = 4'b0001 << addr_q[1:0];
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Array has no reset; state_q being held in IDLE by reset blocks commits.
    always_ff @(posedge cpu_clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[addr_q[ADDR_W-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_mem_slave
// Description : Bench for ahbl_mem_slave at WAIT_CYC 0, 2 and 3 on a shared bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_mem_slave;

    logic        cpu_clk = 1'b0;
    logic        pg_reset_b = 1'b0;
    logic [2:0]  hsel_v = 3'b000;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic [31:0] hwdata = 32'd0;
    wire  [2:0]  rdy_v;
    wire  [2:0]  resp_v;
    wire  [31:0] rdata_v [3];

    int checks = 0;
    int failures = 0;

    always #5 cpu_clk = ~cpu_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahbl_mem_slave #(.ADDR_W(16), .WAIT_CYC(g == 0 ? 0 : g + 1)) u_dut (
            .cpu_clk   (cpu_clk),
            .pg_reset_b(pg_reset_b),
            .hsel      (hsel_v[g]),
            .haddr     (haddr),
            .htrans    (htrans),
            .hsize     (hsize),
            .hwrite    (hwrite),
            .hburst    (hburst),
            .hprot     (hprot),
            .hwdata    (hwdata),
            .hready_in (rdy_v[g]),
            .hready_out(rdy_v[g]),
            .hresp     (resp_v[g]),
            .hrdata    (rdata_v[g])
        );
    end

    typedef struct {
        int        dut;
        bit        idle;
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        autoexp;
        int        cyc;
        bit        resp;
        bit        chk;
        bit [31:0] rdata;
    } xfer_t;

    xfer_t q[$];
    logic [7:0] mdl [int];

    function automatic int wc(int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    function automatic int key(int d, bit [31:0] a);
        return (d << 24) | int'({12'd0, a[19:0]});
    endfunction

    function automatic bit illegal(bit [2:0] sz, bit [31:0] a);
        int nbytes;
        if (sz > 3'd2) return 1'b1;
        nbytes = 1 << sz;
        if ((a % nbytes) != 0) return 1'b1;
        return a >= 32'h0001_0000;
    endfunction

    function automatic void model_write(int d, bit [2:0] sz, bit [31:0] a, bit [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            bit [31:0] b = a + i;
            mdl[key(d, b)] = wd[8*(b % 4) +: 8];
        end
    endfunction

    function automatic bit model_read(int d, bit [31:0] a, output bit [31:0] w);
        bit known = 1'b1;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bit [31:0] b = (a & ~32'd3) + i;
            if (mdl.exists(key(d, b))) w[8*i +: 8] = mdl[key(d, b)];
            else known = 1'b0;
        end
        return known;
    endfunction

    function automatic xfer_t tx(int d, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd,
                                 int cyc, bit resp, bit chk, bit [31:0] rd);
        xfer_t x;
        x.dut = d; x.idle = 1'b0; x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = sz;
        x.addr = a; x.wdata = wd; x.autoexp = 1'b0; x.cyc = cyc; x.resp = resp;
        x.chk = chk; x.rdata = rd;
        return x;
    endfunction

    function automatic xfer_t ax(int d, bit wr, bit [2:0] sz, bit [31:0] a, bit [31:0] wd);
        xfer_t x = tx(d, wr, sz, a, wd, 0, 1'b0, 1'b0, 32'd0);
        x.autoexp = 1'b1;
        x.trans = $urandom_range(0, 1) ? 2'b11 : 2'b10;
        return x;
    endfunction

    function automatic xfer_t ix(int d, int kind);
        xfer_t x = tx(d, 1'b0, 3'd2, 32'd0, 32'd0, 0, 1'b0, 1'b0, 32'd0);
        x.idle = 1'b1;
        x.sel = (kind != 2);
        x.trans = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
        return x;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(xfer_t x);
        hsel_v = 3'b000;
        hsel_v[x.dut] = x.sel;
        htrans = x.trans;
        hwrite = x.idle ? 1'($urandom_range(0, 1)) : x.wr;
        hsize  = x.size;
        haddr  = x.addr;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
    endtask

    // Pipelined master: drives at negedge, samples outputs at the same negedge.
    task automatic run_seq();
        xfer_t cur;
        bit    have = 1'b0;
        int    k = 0;
        int    last_dut = 0;
        int    guard = 0;
        bit    done;
        while ((have || q.size() > 0) && guard < 4000) begin
            @(negedge cpu_clk);
            guard++;
            hwdata = (have && cur.wr) ? cur.wdata : $urandom;
            done = 1'b1;
            if (have) begin
                int d = cur.dut;
                bit fin = (k == cur.cyc - 1);
                string nm = $sformatf("d%0d a=%h wr=%0d sz=%0d k=%0d", d, cur.addr, cur.wr, cur.size, k);
                check({nm, " hready_out"}, 32'(rdy_v[d]), 32'(fin));
                check({nm, " hresp"}, 32'(resp_v[d]), 32'(cur.resp));
                if (!fin || cur.chk)
                    check({nm, " hrdata"}, rdata_v[d], fin ? cur.rdata : 32'd0);
                done = rdy_v[d];
                if (k > cur.cyc + 20) begin
                    checks++; failures++;
                    $display("FAIL %s timeout: hready_out stuck at %0d expected 1", nm, rdy_v[d]);
                    done = 1'b1;
                end
            end else begin
                string nm = $sformatf("d%0d no-phase", last_dut);
                check({nm, " hready_out"}, 32'(rdy_v[last_dut]), 32'd1);
                check({nm, " hresp"}, 32'(resp_v[last_dut]), 32'd0);
                check({nm, " hrdata"}, rdata_v[last_dut], 32'd0);
            end
            if (done) begin
                if (have && cur.wr && !cur.resp) model_write(cur.dut, cur.size, cur.addr, cur.wdata);
                have = 1'b0;
                k = 0;
                hsel_v = 3'b000;
                htrans = 2'b00;
                if (q.size() > 0) begin
                    xfer_t nx = q.pop_front();
                    drive(nx);
                    last_dut = nx.dut;
                    if (!nx.idle) begin
                        if (nx.autoexp) begin
                            nx.resp = illegal(nx.size, nx.addr);
                            nx.cyc  = nx.resp ? 2 : wc(nx.dut) + 1;
                            nx.chk  = 1'b1;
                            nx.rdata = 32'd0;
                            if (!nx.resp && !nx.wr) nx.chk = model_read(nx.dut, nx.addr, nx.rdata);
                        end
                        cur = nx;
                        have = 1'b1;
                    end
                end
            end else begin
                k++;
            end
        end
        if (guard >= 4000) begin
            checks++; failures++;
            $display("FAIL run_seq budget: cycles %0d expected below 4000", guard);
            q.delete();
        end
        @(negedge cpu_clk);
        hsel_v = 3'b000;
        htrans = 2'b00;
    endtask

    initial begin
        xfer_t vec[$];
        vec.push_back(tx(0, 1, 2, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h0));
        vec.push_back(tx(0, 0, 2, 32'h10, 32'h0,        1, 0, 1, 32'hDEADBEEF));
        vec.push_back(tx(0, 1, 2, 32'h20, 32'h11223344, 1, 0, 1, 32'h0));
        vec.push_back(tx(0, 1, 0, 32'h21, 32'h0000AA00, 1, 0, 1, 32'h0));
        vec.push_back(tx(0, 0, 2, 32'h20, 32'h0,        1, 0, 1, 32'h1122AA44));
        vec.push_back(tx(0, 1, 2, 32'h00, 32'hCAFEF00D, 1, 0, 1, 32'h0));
        vec.push_back(tx(0, 1, 2, 32'h02, 32'h99999999, 2, 1, 1, 32'h0));
        vec.push_back(tx(0, 0, 2, 32'h00, 32'h0,        1, 0, 1, 32'hCAFEF00D));
        vec.push_back(tx(0, 0, 2, 32'h10000, 32'h0,     2, 1, 1, 32'h0));
        vec.push_back(tx(0, 0, 3, 32'h04, 32'h0,        2, 1, 1, 32'h0));
        vec.push_back(tx(0, 1, 1, 32'h21, 32'h77777777, 2, 1, 1, 32'h0));
        vec.push_back(ix(0, 1));
        vec.push_back(tx(0, 1, 1, 32'h22, 32'h55660000, 1, 0, 1, 32'h0));
        vec.push_back(tx(0, 0, 1, 32'h20, 32'h0,        1, 0, 1, 32'h5566AA44));
        vec.push_back(ix(1, 2));
        vec.push_back(tx(1, 1, 2, 32'h40, 32'h0BADC0DE, 3, 0, 1, 32'h0));
        vec.push_back(tx(1, 0, 2, 32'h40, 32'h0,        3, 0, 1, 32'h0BADC0DE));
        vec.push_back(tx(1, 0, 2, 32'h42, 32'h0,        2, 1, 1, 32'h0));
        vec.push_back(tx(2, 1, 2, 32'h44, 32'h01020304, 4, 0, 1, 32'h0));
        vec.push_back(tx(2, 1, 1, 32'h46, 32'hBEEF0000, 4, 0, 1, 32'h0));
        vec.push_back(tx(2, 0, 2, 32'h44, 32'h0,        4, 0, 1, 32'hBEEF0304));
        vec.push_back(tx(2, 1, 2, 32'h10000, 32'h0,     2, 1, 1, 32'h0));

        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset hready_out", d), 32'(rdy_v[d]), 32'd1);
            check($sformatf("d%0d reset hresp", d), 32'(resp_v[d]), 32'd0);
            check($sformatf("d%0d reset hrdata", d), rdata_v[d], 32'd0);
        end
        repeat (3) @(negedge cpu_clk);
        pg_reset_b = 1'b1;

        for (int i = 0; i < vec.size(); i++) q.push_back(vec[i]);
        run_seq();

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) q.push_back(ax(d, 1, 2, 32'h100 + 4 * i, $urandom));
            for (int i = 0; i < 50; i++) begin
                int r = $urandom_range(0, 9);
                if (r < 2) begin
                    q.push_back(ix(d, $urandom_range(0, 2)));
                end else begin
                    int s = $urandom_range(0, 9);
                    bit [31:0] a = 32'h100 + $urandom_range(0, 63);
                    if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(16, 31));
                    q.push_back(ax(d, 1'($urandom_range(0, 1)),
                                   (s < 3) ? 3'd0 : (s < 6) ? 3'd1 : (s < 9) ? 3'd2 : 3'd3,
                                   a, $urandom));
                end
            end
        end
        run_seq();

        q.push_back(ax(2, 1, 2, 32'h80, 32'h12345678));
        run_seq();
        hsel_v = 3'b100; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h80;
        @(negedge cpu_clk);
        hsel_v = 3'b000; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        check("abort wait1 hready_out", 32'(rdy_v[2]), 32'd0);
        @(negedge cpu_clk);
        check("abort wait2 hready_out", 32'(rdy_v[2]), 32'd0);
        pg_reset_b = 1'b0;
        #1;
        check("abort reset hready_out", 32'(rdy_v[2]), 32'd1);
        check("abort reset hresp", 32'(resp_v[2]), 32'd0);
        check("abort reset hrdata", rdata_v[2], 32'd0);
        repeat (2) @(negedge cpu_clk);
        pg_reset_b = 1'b1;
        q.push_back(tx(2, 0, 2, 32'h80, 32'h0, 4, 0, 1, 32'h12345678));
        run_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
